// File: rtl/fsic_wb_pkg.sv
// Shared types and constants for the Wishbone user-window fan-out block.
package fsic_wb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StErr  = 2'd3
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int unsigned TMO_CNT_W    = 10;
  localparam int unsigned ERR_CNT_W    = 8;

  // A single channel still needs a 1-bit index vector to stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_ch_decode.sv
// Combinational window and channel decode for the user Wishbone window.
module wb_ch_decode #(
  parameter int unsigned NCH      = 4,
  parameter logic [31:0] BASE     = 32'h3000_0000,
  parameter int unsigned CH_SHIFT = 12,
  parameter int unsigned WIN_BITS = 16,
  parameter int unsigned IDX_W    = 2
) (
  input  logic [31:0]      adr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] NchL = (IDX_W + 1)'(NCH);

  logic [31:0]      off;
  logic [IDX_W-1:0] field;
  logic             in_win;
  logic             in_ch;

  always_comb begin
    off    = adr - BASE;
    in_win = (adr >= BASE) && ((off >> WIN_BITS) == 32'd0);
    field  = adr[CH_SHIFT +: IDX_W];
    // With one channel the select field has zero width, so every in-window address maps to 0.
    in_ch  = (NCH == 1) || ({1'b0, field} < NchL);
    idx    = (NCH == 1) ? '0 : field;
    hit    = in_win && in_ch;
  end

endmodule

// File: rtl/wb_slave_fanout.sv
// Wishbone slave that forwards user-window accesses to one of NCH downstream channels,
// with timeout and out-of-range error termination.
module wb_slave_fanout
  import fsic_wb_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter logic [31:0] BASE     = 32'h3000_0000,
  parameter int unsigned CH_SHIFT = 12,
  parameter int unsigned WIN_BITS = 16,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [31:0]       wbs_adr,
  input  logic [31:0]       wbs_wdata,
  input  logic [3:0]        wbs_sel,
  input  logic              wbs_cyc,
  input  logic              wbs_stb,
  input  logic              wbs_we,
  output logic              wbs_ack,
  output logic [31:0]       wbs_rdata,
  output logic [NCH-1:0]    ch_cyc,
  output logic [NCH-1:0]    ch_stb,
  output logic              ch_we,
  output logic [31:0]       ch_adr,
  output logic [31:0]       ch_wdata,
  output logic [3:0]        ch_sel,
  input  logic [NCH-1:0]    ch_ack,
  input  logic [NCH*32-1:0] ch_rdata,
  output logic              err_irq,
  output logic [7:0]        err_cnt,
  input  logic              err_clr
);

  localparam int unsigned IdxW = idx_width(NCH);

  state_e               state_q, state_d;
  logic [TMO_CNT_W-1:0] tmo_q, tmo_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 we_q, we_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [3:0]           sel_q, sel_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 dec_hit;
  logic [IdxW-1:0]      dec_idx;
  logic [NCH-1:0]       sel_oh;
  logic                 err_entry;

  wb_ch_decode #(
    .NCH      (NCH),
    .BASE     (BASE),
    .CH_SHIFT (CH_SHIFT),
    .WIN_BITS (WIN_BITS),
    .IDX_W    (IdxW)
  ) u_decode (
    .adr (wbs_adr),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (wbs_cyc && wbs_stb) begin
          if (dec_hit) begin
            idx_d   = dec_idx;
            we_d    = wbs_we;
            adr_d   = wbs_adr;
            wdata_d = wbs_wdata;
            sel_d   = wbs_sel;
            tmo_d   = '0;
            state_d = StReq;
          end else begin
            state_d = StErr;
          end
        end
      end
      StReq: begin
        // A master abandoning the cycle wins over a same-cycle ack or timeout.
        if (!wbs_cyc) begin
          state_d = StIdle;
        end else if (ch_ack[idx_q]) begin
          rdata_d = we_q ? 32'd0 : ch_rdata[{idx_q, 5'd0} +: 32];
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + TMO_CNT_W'(1);
          if (tmo_d == TMO_CNT_W'(TIMEOUT)) state_d = StErr;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_entry = (state_q != StErr) && (state_d == StErr);
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = err_entry ? ERR_CNT_W'(1) : '0;
    end else if (err_entry && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sel_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < NCH; i++) sel_oh[i] = (idx_q == IdxW'(i));
  end

  assign ch_cyc    = (state_q == StReq) ? sel_oh : '0;
  assign ch_stb    = (state_q == StReq) ? sel_oh : '0;
  assign ch_we     = we_q;
  assign ch_adr    = adr_q;
  assign ch_wdata  = wdata_q;
  assign ch_sel    = sel_q;
  assign wbs_ack   = (state_q == StResp) || (state_q == StErr);
  assign wbs_rdata = (state_q == StResp) ? rdata_q :
                     (state_q == StErr)  ? ERR_DATA : 32'd0;
  assign err_irq   = (state_q == StErr);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_wb_slave_fanout.sv
// Randomized self-checking bench for wb_slave_fanout against a transaction-level model.
module tb_wb_slave_fanout;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int          TMO      = 8;

  logic         wb_clk = 1'b0;
  logic         wb_rst;
  logic [31:0]  wbs_adr, wbs_wdata;
  logic [3:0]   wbs_sel;
  logic         wbs_cyc, wbs_stb, wbs_we;
  logic         wbs_ack;
  logic [31:0]  wbs_rdata;
  logic [3:0]   ch_cyc, ch_stb;
  logic         ch_we;
  logic [31:0]  ch_adr, ch_wdata;
  logic [3:0]   ch_sel;
  logic [3:0]   ch_ack;
  logic [127:0] ch_rdata;
  logic         err_irq;
  logic [7:0]   err_cnt;
  logic         err_clr;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_m = 0;
  bit in_ack = 1'b0;

  always #5 wb_clk = ~wb_clk;

  wb_slave_fanout #(
    .NCH     (4),
    .BASE    (BASE),
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .wbs_adr   (wbs_adr),
    .wbs_wdata (wbs_wdata),
    .wbs_sel   (wbs_sel),
    .wbs_cyc   (wbs_cyc),
    .wbs_stb   (wbs_stb),
    .wbs_we    (wbs_we),
    .wbs_ack   (wbs_ack),
    .wbs_rdata (wbs_rdata),
    .ch_cyc    (ch_cyc),
    .ch_stb    (ch_stb),
    .ch_we     (ch_we),
    .ch_adr    (ch_adr),
    .ch_wdata  (ch_wdata),
    .ch_sel    (ch_sel),
    .ch_ack    (ch_ack),
    .ch_rdata  (ch_rdata),
    .err_irq   (err_irq),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ack"}, wbs_ack, 0);
    chk({tag, " rdata"}, wbs_rdata, 0);
    chk({tag, " irq"}, err_irq, 0);
    chk({tag, " stb"}, ch_stb, 0);
    chk({tag, " cyc"}, ch_cyc, 0);
  endtask

  // One complete master transaction; ack_dly = stb cycles the target waits before acking.
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                      input logic [3:0] sel, input int ack_dly, input logic [31:0] rd,
                      input bit noise, input bit hold);
    bit          hit;
    bit          tmo;
    bit          clr;
    int          ch;
    int          req_len;
    logic [3:0]  oh;
    logic [31:0] exp_rd;
    hit = (adr >= BASE) && ((adr - BASE) < 32'h0001_0000);
    ch  = int'((adr >> 12) % 4);
    oh  = 4'(1 << ch);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_adr = adr; wbs_we = we;
    wbs_wdata = wd; wbs_sel = sel;
    if (in_ack) begin
      @(negedge wb_clk);
      chk_quiet("b2b_idle");
    end
    clr = err_clr;
    if (clr) cnt_m = 0;
    if (!hit) begin
      @(negedge wb_clk);
      err_clr = 1'b0;
      if (cnt_m < 255) cnt_m++;
      chk("oor ack", wbs_ack, 1);
      chk("oor rdata", wbs_rdata, ERR_DATA);
      chk("oor irq", err_irq, 1);
      chk("oor stb", ch_stb, 0);
      chk("oor err_cnt", err_cnt, cnt_m);
    end else begin
      tmo     = !(ack_dly >= 0 && ack_dly < TMO);
      req_len = tmo ? TMO : ack_dly + 1;
      exp_rd  = tmo ? ERR_DATA : (we ? 32'd0 : rd);
      for (int c = 0; c < req_len; c++) begin
        @(negedge wb_clk);
        err_clr = 1'b0;
        chk("req ch_stb", ch_stb, oh);
        chk("req ch_cyc", ch_cyc, oh);
        chk("req wbs_ack", wbs_ack, 0);
        chk("req ch_adr", ch_adr, adr);
        chk("req ch_we", ch_we, we);
        chk("req ch_wdata", ch_wdata, wd);
        chk("req ch_sel", ch_sel, sel);
        ch_ack   = noise ? (4'($urandom) & ~oh) : 4'b0;
        ch_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (c == ack_dly) begin
          ch_ack[ch] = 1'b1;
          ch_rdata[ch*32 +: 32] = rd;
        end
      end
      @(negedge wb_clk);
      ch_ack = 4'b0;
      if (tmo && cnt_m < 255) cnt_m++;
      chk("resp ack", wbs_ack, 1);
      chk("resp rdata", wbs_rdata, exp_rd);
      chk("resp irq", err_irq, tmo);
      chk("resp stb", ch_stb, 0);
      chk("resp err_cnt", err_cnt, cnt_m);
    end
    in_ack = 1'b1;
    if (!hold) begin
      wbs_cyc = 1'b0; wbs_stb = 1'b0;
      @(negedge wb_clk);
      chk_quiet("post_idle");
      in_ack = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] adr;
    int          r;
    wb_rst = 1'b1; wbs_adr = '0; wbs_wdata = '0; wbs_sel = '0;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    ch_ack = '0; ch_rdata = '0; err_clr = 1'b0;
    repeat (2) @(negedge wb_clk);
    chk_quiet("reset");
    chk("reset err_cnt", err_cnt, 0);
    chk("reset ch_adr", ch_adr, 0);
    wb_rst = 1'b0;
    @(negedge wb_clk);

    // Directed scenarios
    xfer(32'h3000_1004, 1'b0, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b0, 1'b0);
    xfer(32'h3000_3000, 1'b1, 32'hA5A5_A5A5, 4'b0011, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    xfer(32'h3001_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    chk("first error count", err_cnt, 1);
    xfer(32'h3000_2000, 1'b0, 32'h0, 4'hF, -1, 32'h0, 1'b1, 1'b0);
    xfer(32'h2FFF_FFFC, 1'b1, 32'h1111_2222, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    xfer(32'h3000_FFFC, 1'b0, 32'h0, 4'h1, TMO - 1, 32'hCAFE_F00D, 1'b1, 1'b1);
    xfer(32'h3000_0010, 1'b0, 32'h0, 4'hF, 0, 32'h0BAD_CAFE, 1'b0, 1'b1);
    xfer(32'h3002_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      adr = BASE + ($urandom & 32'h0000_FFFC);
      else if (r < 9) adr = BASE + 32'h0001_0000 + ($urandom & 32'h000F_FFFC);
      else            adr = BASE - 32'd4 - ($urandom & 32'h0000_FFFC);
      xfer(adr, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 10), $urandom,
           1'($urandom), 1'($urandom));
    end
    if (in_ack) begin
      wbs_cyc = 1'b0; wbs_stb = 1'b0;
      @(negedge wb_clk);
      chk_quiet("rand_tail");
      in_ack = 1'b0;
    end

    // Master drops cyc in the third REQ cycle
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_adr = 32'h3000_0008; wbs_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge wb_clk);
      chk("abort ch_stb", ch_stb, 4'b0001);
    end
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    ch_ack = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge wb_clk);
      ch_ack = 4'b0;
      chk_quiet("abort");
      chk("abort err_cnt", err_cnt, cnt_m);
    end

    // Reset in the middle of a REQ phase
    xfer(32'h3000_9000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_adr = 32'h3000_1010; wbs_we = 1'b1;
    wbs_wdata = 32'h5A5A_0001; wbs_sel = 4'b1100;
    @(negedge wb_clk);
    chk("rst_mid ch_stb", ch_stb, 4'b0010);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    cnt_m = 0;
    chk_quiet("rst_mid");
    chk("rst_mid ch_we", ch_we, 0);
    chk("rst_mid ch_adr", ch_adr, 0);
    chk("rst_mid ch_wdata", ch_wdata, 0);
    chk("rst_mid ch_sel", ch_sel, 0);
    chk("rst_mid err_cnt", err_cnt, 0);
    wb_rst = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
    @(negedge wb_clk);
    chk_quiet("rst_after");

    // Saturation, clear, and clear coinciding with an error
    for (int i = 0; i < 260; i++) xfer(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    chk("sat err_cnt", err_cnt, 255);
    err_clr = 1'b1;
    @(negedge wb_clk);
    err_clr = 1'b0;
    cnt_m = 0;
    chk("clr err_cnt", err_cnt, 0);
    xfer(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    xfer(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    err_clr = 1'b1;
    xfer(32'h3001_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    chk("clr_with_err err_cnt", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
